// File: rtl/stream_mux_arb_pkg.sv
// Shared definitions for the stream multiplexer: mode encoding and a width helper.
package mux_pkg;

  typedef enum logic {
    MODE_SEL = 1'b0,
    MODE_RR  = 1'b1
  } mode_e;

  // Index width for n items, never less than one bit.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < n) r++;
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/stream_mux_arb_if.sv
// Handshake bundle between N producers, the mux, and the shared consumer.
interface stream_mux_arb_if
  import mux_pkg::*;
#(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned DATA_W = 8
);
  localparam int unsigned SEL_W = clog2(NUM_CH);

  logic                       i_Mode;
  logic [SEL_W-1:0]           i_Select;
  logic [NUM_CH-1:0]          i_Valid;
  logic [NUM_CH-1:0]          i_Last;
  logic [NUM_CH*DATA_W-1:0]   i_Data;
  logic [NUM_CH-1:0]          o_Ready;
  logic                       o_Valid;
  logic [DATA_W-1:0]          o_Data;
  logic                       o_Last;
  logic [SEL_W-1:0]           o_Channel;
  logic                       i_Ready;

  modport slave (
    input  i_Mode, i_Select, i_Valid, i_Last, i_Data, i_Ready,
    output o_Ready, o_Valid, o_Data, o_Last, o_Channel
  );

  modport master (
    output i_Mode, i_Select, i_Valid, i_Last, i_Data, i_Ready,
    input  o_Ready, o_Valid, o_Data, o_Last, o_Channel
  );

endinterface

// File: rtl/stream_mux_arb_rr_arbiter.sv
// Combinational round-robin arbiter: first request searching upward from ptr+1, wrapping.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter int unsigned NUM_CH = 4
)(
  input  logic [NUM_CH-1:0]          req,
  input  logic [clog2(NUM_CH)-1:0]   ptr,
  output logic [NUM_CH-1:0]          grant,
  output logic [clog2(NUM_CH)-1:0]   idx,
  output logic                       any
);
  localparam int unsigned SEL_W = clog2(NUM_CH);

  logic [SEL_W-1:0] c;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    c     = '0;
    for (int unsigned off = 1; off <= NUM_CH; off++) begin
      c = SEL_W'((32'(ptr) + off) % NUM_CH);
      if (!any && req[c]) begin
        any      = 1'b1;
        idx      = c;
        grant[c] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/stream_mux_arb.sv
// N-channel packet-aware stream mux with explicit-select or round-robin grant and a
// single registered output stage.
module stream_mux_arb
  import mux_pkg::*;
#(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned DATA_W = 8
)(
  input  logic             i_Clk,
  input  logic             i_Rst,
  stream_mux_arb_if.slave  bus
);
  localparam int unsigned SEL_W = clog2(NUM_CH);

  logic                    lock;
  logic [SEL_W-1:0]        lock_ch;
  logic [SEL_W-1:0]        ptr;

  logic [NUM_CH-1:0]       rr_grant;
  logic [SEL_W-1:0]        rr_idx;
  logic                    rr_any;

  logic [(1<<SEL_W)-1:0]   sel_ok;
  logic [SEL_W-1:0]        cand;
  logic                    cand_ok;
  logic                    out_free;
  logic [NUM_CH-1:0]       ready;
  logic [DATA_W-1:0]       sel_data;
  logic                    sel_last;

  rr_arbiter #(.NUM_CH(NUM_CH)) u_rr_arbiter (
    .req   (bus.i_Valid),
    .ptr   (ptr),
    .grant (rr_grant),
    .idx   (rr_idx),
    .any   (rr_any)
  );

  // Select codes beyond the channel count never grant.
  for (genvar i = 0; i < (1 << SEL_W); i++) begin : g_sel_ok
    assign sel_ok[i] = (i < NUM_CH);
  end

  assign out_free = !bus.o_Valid || bus.i_Ready;

  always_comb begin
    cand    = '0;
    cand_ok = 1'b0;
    if (lock) begin
      cand    = lock_ch;
      cand_ok = 1'b1;
    end else if (bus.i_Mode == MODE_SEL) begin
      cand    = bus.i_Select;
      cand_ok = sel_ok[bus.i_Select];
    end else begin
      cand    = rr_idx;
      cand_ok = rr_any;
    end
  end

  always_comb begin
    ready    = '0;
    sel_data = '0;
    sel_last = 1'b0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if (SEL_W'(k) == cand) begin
        sel_data = bus.i_Data[k*DATA_W +: DATA_W];
        sel_last = bus.i_Last[k];
        ready[k] = cand_ok && out_free && bus.i_Valid[k];
      end
    end
    // Unlocked round-robin: the arbiter grant already implies a valid request.
    if (!lock && bus.i_Mode == MODE_RR)
      ready = out_free ? rr_grant : '0;
  end

  assign bus.o_Ready = ready;

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      bus.o_Valid   <= 1'b0;
      bus.o_Data    <= '0;
      bus.o_Last    <= 1'b0;
      bus.o_Channel <= '0;
      lock          <= 1'b0;
      lock_ch       <= '0;
      ptr           <= SEL_W'(NUM_CH - 1);
    end else if (out_free) begin
      if (|ready) begin
        bus.o_Valid   <= 1'b1;
        bus.o_Data    <= sel_data;
        bus.o_Last    <= sel_last;
        bus.o_Channel <= cand;
        if (!sel_last) begin
          lock    <= 1'b1;
          lock_ch <= cand;
        end else begin
          lock <= 1'b0;
          if (bus.i_Mode == MODE_RR)
            ptr <= cand;
        end
      end else begin
        bus.o_Valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_stream_mux_arb.sv
// Directed and randomized checks of stream_mux_arb against a packet-level reference model.
module tb_stream_mux_arb;
  import mux_pkg::*;

  localparam int N = 4;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  stream_mux_arb_if #(.NUM_CH(N), .DATA_W(W)) bus ();

  stream_mux_arb #(.NUM_CH(N), .DATA_W(W)) dut (
    .i_Clk (clk),
    .i_Rst (rst),
    .bus   (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit         m_init = 0;
  bit         m_valid, m_last, m_lock;
  logic [7:0] m_data;
  int         m_ch, m_lch, m_ptr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Channel that would be accepted this cycle if the output were free, or -1.
  function automatic int model_grant();
    if (m_lock) return bus.i_Valid[m_lch] ? m_lch : -1;
    if (bus.i_Mode == MODE_SEL)
      return (int'(bus.i_Select) < N && bus.i_Valid[bus.i_Select]) ? int'(bus.i_Select) : -1;
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (m_ptr + k) % N;
      if (bus.i_Valid[c]) return c;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] model_ready();
    logic [N-1:0] r;
    int g;
    r = '0;
    g = model_grant();
    if (g >= 0 && (!m_valid || bus.i_Ready)) r[g] = 1'b1;
    return r;
  endfunction

  task automatic model_clock();
    int g;
    if (rst) begin
      m_init = 1; m_valid = 0; m_data = '0; m_last = 0; m_ch = 0;
      m_lock = 0; m_lch = 0; m_ptr = N - 1;
    end else if (m_init && (!m_valid || bus.i_Ready)) begin
      g = model_grant();
      if (g >= 0) begin
        m_valid = 1;
        m_data  = bus.i_Data[g*W +: W];
        m_last  = bus.i_Last[g];
        m_ch    = g;
        if (!m_last) begin
          m_lock = 1; m_lch = g;
        end else begin
          m_lock = 0;
          if (bus.i_Mode == MODE_RR) m_ptr = g;
        end
      end else begin
        m_valid = 0;
      end
    end
  endtask

  // One clock: check o_Ready mid-cycle, advance model at the edge, check outputs after it.
  task automatic step();
    @(negedge clk);
    if (m_init) chk("o_Ready", 32'(bus.o_Ready), 32'(model_ready()));
    @(posedge clk);
    model_clock();
    #1;
    if (m_init) begin
      chk("o_Valid", 32'(bus.o_Valid), 32'(m_valid));
      if (m_valid) begin
        chk("o_Data", 32'(bus.o_Data), 32'(m_data));
        chk("o_Last", 32'(bus.o_Last), 32'(m_last));
        chk("o_Channel", 32'(bus.o_Channel), 32'(m_ch));
      end
    end
  endtask

  initial begin
    logic [7:0] held_d;
    logic       held_l;
    logic [1:0] held_c;

    rst          = 1'b1;
    bus.i_Mode   = MODE_SEL;
    bus.i_Select = '0;
    bus.i_Valid  = '0;
    bus.i_Last   = '0;
    bus.i_Data   = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    bus.i_Ready  = 1'b1;
    step();
    chk("rst_o_Valid", 32'(bus.o_Valid), 32'd0);
    chk("rst_o_Data", 32'(bus.o_Data), 32'd0);
    chk("rst_o_Channel", 32'(bus.o_Channel), 32'd0);

    // Explicit select of channel 2 with every channel offering single beats
    rst = 1'b0;
    bus.i_Mode = MODE_SEL; bus.i_Select = 2'd2; bus.i_Valid = 4'b1111; bus.i_Last = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("sel_channel", 32'(bus.o_Channel), 32'd2);
      chk("sel_data", 32'(bus.o_Data), 32'hA2);
      chk("sel_ready", 32'(bus.o_Ready), 32'b0100);
    end

    // Round-robin over single-beat packets starts at channel 0
    bus.i_Mode = MODE_RR;
    for (int k = 0; k < 8; k++) begin
      step();
      chk("rr_seq", 32'(bus.o_Channel), 32'(k % 4));
    end
    step();
    chk("rr_wrap", 32'(bus.o_Channel), 32'd0);

    // Channel 1 sends a 3-beat packet while the others stay valid
    bus.i_Last = 4'b1101;
    step();
    chk("pkt_ch_b0", 32'(bus.o_Channel), 32'd1);
    chk("pkt_last_b0", 32'(bus.o_Last), 32'd0);
    step();
    chk("pkt_ch_b1", 32'(bus.o_Channel), 32'd1);
    chk("pkt_last_b1", 32'(bus.o_Last), 32'd0);
    bus.i_Last = 4'b1111;
    step();
    chk("pkt_ch_b2", 32'(bus.o_Channel), 32'd1);
    chk("pkt_last_b2", 32'(bus.o_Last), 32'd1);
    step();
    chk("pkt_next", 32'(bus.o_Channel), 32'd2);

    // Backpressure holds the output stage
    held_d = bus.o_Data; held_l = bus.o_Last; held_c = bus.o_Channel;
    bus.i_Ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("bp_ready", 32'(bus.o_Ready), 32'd0);
      chk("bp_data", 32'(bus.o_Data), 32'(held_d));
      chk("bp_last", 32'(bus.o_Last), 32'(held_l));
      chk("bp_chan", 32'(bus.o_Channel), 32'(held_c));
      chk("bp_valid", 32'(bus.o_Valid), 32'd1);
    end
    bus.i_Ready = 1'b1;
    step();
    chk("bp_resume", 32'(bus.o_Channel), 32'd3);
    step();

    // Locked on ch3; mode/select changes wait for the unlocking beat
    bus.i_Valid = 4'b1000; bus.i_Last = 4'b0000;
    step();
    chk("lock3_start", 32'(bus.o_Channel), 32'd3);
    bus.i_Mode = MODE_SEL; bus.i_Select = 2'd0; bus.i_Valid = 4'b1111; bus.i_Last = 4'b0111;
    step();
    chk("lock3_hold0", 32'(bus.o_Channel), 32'd3);
    step();
    chk("lock3_hold1", 32'(bus.o_Channel), 32'd3);
    bus.i_Last = 4'b1111;
    step();
    chk("lock3_end", 32'(bus.o_Channel), 32'd3);
    chk("lock3_end_last", 32'(bus.o_Last), 32'd1);
    step();
    chk("lock3_after", 32'(bus.o_Channel), 32'd0);

    // Reset mid-packet aborts the packet and restarts RR from channel 0
    bus.i_Mode = MODE_RR; bus.i_Valid = 4'b0100; bus.i_Last = 4'b0000;
    step();
    chk("abort_pre", 32'(bus.o_Valid), 32'd1);
    rst = 1'b1; bus.i_Valid = 4'b0000;
    step();
    chk("abort_valid", 32'(bus.o_Valid), 32'd0);
    chk("abort_ready", 32'(bus.o_Ready), 32'd0);
    rst = 1'b0; bus.i_Valid = 4'b0110; bus.i_Last = 4'b1111;
    step();
    chk("abort_rr", 32'(bus.o_Channel), 32'd1);

    // Randomized traffic against the model
    for (int k = 0; k < 600; k++) begin
      rst          = ($urandom_range(0, 79) == 0);
      bus.i_Mode   = (($urandom_range(0, 7) == 0) ? ~bus.i_Mode : bus.i_Mode);
      bus.i_Select = 2'($urandom_range(0, 3));
      bus.i_Valid  = 4'($urandom);
      bus.i_Last   = {($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0),
                      ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0)};
      bus.i_Data   = $urandom;
      bus.i_Ready  = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
